debug_uart_poll_master: RTL

Host-side counterpart of debug_uart_core, implementing the initiator end of the debug UART link. It accepts a command byte on a valid/ready interface, serializes it 8N1 on out_tx_serial, then waits for the single response byte the core returns (the debug status register selected by the command). It deserializes that byte and reports a response, framing error or timeout. It is used in bench harnesses and as the debug poller in the host-side FPGA design.

---
 rtl/debug_uart_poll_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/debug_uart_poll_master.sv
// Host-side debug UART initiator: sends one 8N1 command byte, then receives the
// single 8N1 response byte, reporting response, framing error or timeout.
module debug_uart_poll_master #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk_uart,
  input  logic       rst,
  input  logic       in_cmd_valid,
  input  logic [7:0] in_cmd_byte,
  output logic       out_cmd_ready,
  output logic       out_tx_serial,
  input  logic       in_rx_serial,
  output logic       out_rsp_valid,
  output logic [7:0] out_rsp_byte,
  output logic       out_frame_err,
  output logic       out_timeout,
  output logic       out_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_q, tx_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rsp_byte_q, rsp_byte_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;

  logic rx_sync;
  logic pulse_any;
  logic accept;

  assign rx_sync   = sync2_q;
  assign pulse_any = rsp_valid_q | frame_err_q | timeout_q;
  // Ready is held off during the result pulse so a back-to-back command lands
  // one cycle after the pulse.
  assign out_cmd_ready = (state_q == S_IDLE) && !rst && !pulse_any;
  assign accept        = in_cmd_valid && out_cmd_ready;

  assign out_tx_serial = tx_q;
  assign out_rsp_valid = rsp_valid_q;
  assign out_rsp_byte  = rsp_byte_q;
  assign out_frame_err = frame_err_q;
  assign out_timeout   = timeout_q;
  assign out_busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_byte_d   = tx_byte_q;
    tx_d        = tx_q;
    to_d        = to_q;
    rx_shift_d  = rx_shift_q;
    rsp_byte_d  = rsp_byte_q;
    rsp_valid_d = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    sync1_d     = in_rx_serial;
    sync2_d     = sync1_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (accept) begin
          tx_byte_d = in_cmd_byte;
          tx_d      = 1'b0;
          state_d   = S_TX_START;
        end
      end
      S_TX_START: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = tx_byte_q[0];
          state_d = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          tx_byte_d = {1'b0, tx_byte_q[7:1]};
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_TX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = tx_byte_q[1];
          end
        end
      end
      S_TX_STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          to_d    = TO_LOAD;
          state_d = S_RX_WAIT;
        end
      end
      S_RX_WAIT: begin
        cnt_d = '0;
        // A start edge takes priority over an expiring window.
        if (!rx_sync) begin
          state_d = S_RX_START;
        end else if (to_q <= TO_ONE) begin
          to_d      = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_d = to_q - TO_ONE;
        end
      end
      S_RX_START: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_sync ? S_RX_WAIT : S_RX_DATA;
        end
      end
      S_RX_DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_RX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_RX_STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_sync) begin
            rsp_byte_d  = rx_shift_q;
            rsp_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_byte_q   <= '0;
      tx_q        <= 1'b1;
      to_q        <= '0;
      rx_shift_q  <= '0;
      rsp_byte_q  <= '0;
      rsp_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_q        <= tx_d;
      to_q        <= to_d;
      rx_shift_q  <= rx_shift_d;
      rsp_byte_q  <= rsp_byte_d;
      rsp_valid_q <= rsp_valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

endmodule
